// File: rtl/wb_pkg.sv
// Shared types and widths for the register-file write-back slice.
package wb_pkg;

   localparam int REG_ADDR_W = 3;
   localparam int DATA_W     = 16;
   localparam int NUM_REGS   = 8;

   typedef struct packed {
      logic [REG_ADDR_W-1:0] dest;
      logic [DATA_W-1:0]     data;
   } wb_req_t;

   typedef enum logic [1:0] {
      SRC_NONE = 2'd0,
      SRC_ALU  = 2'd1,
      SRC_MEM  = 2'd2
   } wb_src_t;

endpackage

// File: rtl/reg_writeback_if.sv
// Producer, decode and register-file write signals of the write-back stage.
interface reg_writeback_if;
   import wb_pkg::*;

   logic                  alu_valid;
   logic                  alu_ready;
   logic [REG_ADDR_W-1:0] alu_dest;
   logic [DATA_W-1:0]     alu_data;

   logic                  mem_valid;
   logic                  mem_ready;
   logic [REG_ADDR_W-1:0] mem_dest;
   logic [DATA_W-1:0]     mem_data;

   logic                  issue_valid;
   logic [REG_ADDR_W-1:0] issue_dest;
   logic [NUM_REGS-1:0]   busy;

   logic                  reg_write_en;
   logic [REG_ADDR_W-1:0] reg_write_dest;
   logic [DATA_W-1:0]     reg_write_data;

   // Write-back stage side: owns the register-file write port.
   modport master (
      input  alu_valid, alu_dest, alu_data,
      input  mem_valid, mem_dest, mem_data,
      input  issue_valid, issue_dest,
      output alu_ready, mem_ready, busy,
      output reg_write_en, reg_write_dest, reg_write_data
   );

   modport slave (
      output alu_valid, alu_dest, alu_data,
      output mem_valid, mem_dest, mem_data,
      output issue_valid, issue_dest,
      input  alu_ready, mem_ready, busy,
      input  reg_write_en, reg_write_dest, reg_write_data
   );

endinterface

// File: rtl/wb_fifo.sv
// In-order load-result buffer; pointers wrap naturally, count is one bit wider.
module wb_fifo
   import wb_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  wb_req_t                push_data,
   input  logic                   pop,
   output wb_req_t                head,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] CNT_EMPTY = CNT_W'(0);

   wb_req_t           mem_r [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_r;
   logic [PTR_W-1:0]  rd_ptr_r;
   logic [CNT_W-1:0]  count_r;
   logic              full_s;
   logic              empty_s;
   logic              do_push_s;
   logic              do_pop_s;

   assign full_s    = (count_r == CNT_FULL);
   assign empty_s   = (count_r == CNT_EMPTY);
   assign do_push_s = push && !full_s;
   assign do_pop_s  = pop && !empty_s;

   // Pointer and occupancy state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_r <= {PTR_W{1'b0}};
         rd_ptr_r <= {PTR_W{1'b0}};
         count_r  <= CNT_EMPTY;
      end else begin
         if (do_push_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE;
         end
         if (do_pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end
         case ({do_push_s, do_pop_s})
            2'b10:   count_r <= count_r + CNT_ONE;
            2'b01:   count_r <= count_r - CNT_ONE;
            default: count_r <= count_r;
         endcase
      end
   end

   // Entry storage; contents are meaningless until written, so no reset.
   always_ff @(posedge clk) begin
      if (do_push_s) begin
         mem_r[wr_ptr_r] <= push_data;
      end
   end

   assign head  = mem_r[rd_ptr_r];
   assign full  = full_s;
   assign empty = empty_s;
   assign count = count_r;

endmodule

// File: rtl/reg_writeback.sv
// Register-file write-port owner: arbitrates ALU and buffered load results,
// bounds load starvation and tracks pending writes for decode hazard stalls.
module reg_writeback
   import wb_pkg::*;
#(
   parameter int DEPTH      = 4,
   parameter int STARVE_MAX = 3
) (
   input  logic            clk,
   input  logic            rst,
   reg_writeback_if.master bus
);

   localparam int CNT_W = $clog2(DEPTH) + 1;
   localparam int STV_W = $clog2(STARVE_MAX + 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
   localparam logic [STV_W-1:0] STV_LIM  = STV_W'(STARVE_MAX);
   localparam logic [STV_W-1:0] STV_ONE  = STV_W'(1);
   localparam logic [STV_W-1:0] STV_ZERO = STV_W'(0);

   wb_req_t             fifo_head_s;
   wb_req_t             mem_req_s;
   wb_req_t             sel_req_s;
   logic                fifo_full_s;
   logic                fifo_empty_s;
   logic [CNT_W-1:0]    fifo_count_s;
   logic                fifo_push_s;
   logic                fifo_pop_s;
   logic                force_s;
   wb_src_t             src_s;
   logic [STV_W-1:0]    starve_r;
   logic [STV_W-1:0]    starve_next_s;
   logic [NUM_REGS-1:0] busy_r;
   logic [NUM_REGS-1:0] busy_next_s;
   logic                wr_en_r;
   logic [REG_ADDR_W-1:0] wr_dest_r;
   logic [DATA_W-1:0]   wr_data_r;

   assign mem_req_s.dest = bus.mem_dest;
   assign mem_req_s.data = bus.mem_data;
   assign fifo_push_s    = bus.mem_valid && !fifo_full_s;
   assign fifo_pop_s     = (src_s == SRC_MEM);

   wb_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (fifo_push_s),
      .push_data (mem_req_s),
      .pop       (fifo_pop_s),
      .head      (fifo_head_s),
      .full      (fifo_full_s),
      .empty     (fifo_empty_s),
      .count     (fifo_count_s)
   );

   assign force_s       = !fifo_empty_s && (starve_r == STV_LIM);
   assign bus.alu_ready = !force_s;
   // No pass-through when full, even if the head leaves this cycle.
   assign bus.mem_ready = (fifo_count_s != CNT_FULL);

   // Source arbitration: starved load head, then ALU, then any load.
   always_comb begin
      src_s = SRC_NONE;
      if (force_s) begin
         src_s = SRC_MEM;
      end else if (bus.alu_valid) begin
         src_s = SRC_ALU;
      end else if (!fifo_empty_s) begin
         src_s = SRC_MEM;
      end else begin
         src_s = SRC_NONE;
      end
   end

   // Winner's destination and data.
   always_comb begin
      sel_req_s.dest = 3'd0;
      sel_req_s.data = 16'h0000;
      case (src_s)
         SRC_ALU: begin
            sel_req_s.dest = bus.alu_dest;
            sel_req_s.data = bus.alu_data;
         end
         SRC_MEM: begin
            sel_req_s = fifo_head_s;
         end
         default: begin
            sel_req_s.dest = 3'd0;
            sel_req_s.data = 16'h0000;
         end
      endcase
   end

   // Starve counter counts ALU wins over a waiting load head, saturating.
   always_comb begin
      starve_next_s = starve_r;
      if (fifo_empty_s || (src_s == SRC_MEM)) begin
         starve_next_s = STV_ZERO;
      end else if ((src_s == SRC_ALU) && (starve_r != STV_LIM)) begin
         starve_next_s = starve_r + STV_ONE;
      end else begin
         starve_next_s = starve_r;
      end
   end

   // Scoreboard: a new issue to r outranks a write retiring r in the same cycle.
   always_comb begin
      busy_next_s = busy_r;
      for (int r = 0; r < NUM_REGS; r++) begin
         if (bus.issue_valid && (bus.issue_dest == REG_ADDR_W'(r))) begin
            busy_next_s[r] = 1'b1;
         end else if ((src_s != SRC_NONE) && (sel_req_s.dest == REG_ADDR_W'(r))) begin
            busy_next_s[r] = 1'b0;
         end else begin
            busy_next_s[r] = busy_r[r];
         end
      end
   end

   // Arbitration state and scoreboard registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         starve_r <= STV_ZERO;
         busy_r   <= {NUM_REGS{1'b0}};
      end else begin
         starve_r <= starve_next_s;
         busy_r   <= busy_next_s;
      end
   end

   // Register-file write port; address and data hold when idle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_en_r   <= 1'b0;
         wr_dest_r <= 3'd0;
         wr_data_r <= 16'h0000;
      end else begin
         wr_en_r <= (src_s != SRC_NONE);
         if (src_s != SRC_NONE) begin
            wr_dest_r <= sel_req_s.dest;
            wr_data_r <= sel_req_s.data;
         end
      end
   end

   assign bus.busy           = busy_r;
   assign bus.reg_write_en   = wr_en_r;
   assign bus.reg_write_dest = wr_dest_r;
   assign bus.reg_write_data = wr_data_r;

endmodule

// File: tb/tb_reg_writeback.sv
// Directed bench for reg_writeback: expected writes are queued as stimulus is
// driven and matched in order against the register-file write port.
module tb_reg_writeback;
   import wb_pkg::*;

   logic clk;
   logic rst;
   int   n_cmp;
   int   n_fail;
   wb_req_t exp_q [$];

   reg_writeback_if bus ();

   reg_writeback #(
      .DEPTH      (4),
      .STARVE_MAX (3)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic expect_write(input logic [2:0] dest, input logic [15:0] data);
      wb_req_t e;
      e.dest = dest;
      e.data = data;
      exp_q.push_back(e);
   endtask

   // Advance one edge, sample 1 time unit later, and match any write.
   task automatic tick();
      wb_req_t e;
      @(posedge clk);
      #1;
      if (bus.reg_write_en === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("spurious_write", 32'(bus.reg_write_en), 32'd0);
         end else begin
            e = exp_q.pop_front();
            check("wr_dest", 32'(bus.reg_write_dest), 32'(e.dest));
            check("wr_data", 32'(bus.reg_write_data), 32'(e.data));
         end
      end
   endtask

   initial begin
      n_cmp  = 0;
      n_fail = 0;
      rst    = 1'b1;
      bus.alu_valid   = 1'b0;
      bus.alu_dest    = 3'd0;
      bus.alu_data    = 16'h0000;
      bus.mem_valid   = 1'b0;
      bus.mem_dest    = 3'd0;
      bus.mem_data    = 16'h0000;
      bus.issue_valid = 1'b0;
      bus.issue_dest  = 3'd0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_en",        32'(bus.reg_write_en),   32'd0);
      check("rst_dest",      32'(bus.reg_write_dest), 32'd0);
      check("rst_data",      32'(bus.reg_write_data), 32'd0);
      check("rst_busy",      32'(bus.busy),           32'h00);
      check("rst_mem_ready", 32'(bus.mem_ready),      32'd1);
      check("rst_alu_ready", 32'(bus.alu_ready),      32'd1);
      rst = 1'b0;
      tick();
      check("idle_en", 32'(bus.reg_write_en), 32'd0);

      // ALU only: issue r3, then write r3
      bus.issue_valid = 1'b1;
      bus.issue_dest  = 3'd3;
      tick();
      check("alu_busy_set", 32'(bus.busy), 32'h08);
      bus.issue_valid = 1'b0;
      bus.alu_valid   = 1'b1;
      bus.alu_dest    = 3'd3;
      bus.alu_data    = 16'h1234;
      check("alu_ready_idle", 32'(bus.alu_ready), 32'd1);
      expect_write(3'd3, 16'h1234);
      tick();
      check("alu_en", 32'(bus.reg_write_en), 32'd1);
      check("alu_busy_clr", 32'(bus.busy), 32'h00);
      bus.alu_valid = 1'b0;
      tick();
      check("alu_en_drop", 32'(bus.reg_write_en), 32'd0);
      check("alu_dest_hold", 32'(bus.reg_write_dest), 32'd3);
      check("alu_data_hold", 32'(bus.reg_write_data), 32'h1234);

      // Conflict: load queued (no bypass), then ALU and FIFO head together
      bus.mem_valid = 1'b1;
      bus.mem_dest  = 3'd2;
      bus.mem_data  = 16'h5555;
      tick();
      check("load_no_bypass", 32'(bus.reg_write_en), 32'd0);
      bus.mem_valid = 1'b0;
      bus.alu_valid = 1'b1;
      bus.alu_dest  = 3'd1;
      bus.alu_data  = 16'hAAAA;
      check("conf_alu_ready", 32'(bus.alu_ready), 32'd1);
      expect_write(3'd1, 16'hAAAA);
      expect_write(3'd2, 16'h5555);
      tick();
      bus.alu_valid = 1'b0;
      check("conf_alu_ready2", 32'(bus.alu_ready), 32'd1);
      tick();
      check("conf_load_en", 32'(bus.reg_write_en), 32'd1);
      tick();
      check("conf_idle", 32'(bus.reg_write_en), 32'd0);

      // Starvation: one queued load, ALU held valid
      bus.mem_valid = 1'b1;
      bus.mem_dest  = 3'd4;
      bus.mem_data  = 16'h4444;
      tick();
      bus.mem_valid = 1'b0;
      bus.alu_valid = 1'b1;
      bus.alu_dest  = 3'd6;
      for (int i = 0; i < 3; i++) begin
         bus.alu_data = 16'(i + 1);
         check("starve_alu_ready", 32'(bus.alu_ready), 32'd1);
         expect_write(3'd6, 16'(i + 1));
         tick();
      end
      bus.alu_data = 16'h0004;
      check("starve_forced", 32'(bus.alu_ready), 32'd0);
      expect_write(3'd4, 16'h4444);
      tick();
      check("starve_resume", 32'(bus.alu_ready), 32'd1);
      expect_write(3'd6, 16'h0004);
      tick();
      bus.alu_valid = 1'b0;
      tick();

      // FIFO full: four loads under continuous ALU traffic, fifth waits
      bus.alu_valid = 1'b1;
      bus.alu_dest  = 3'd7;
      bus.mem_valid = 1'b1;
      for (int k = 0; k < 4; k++) begin
         bus.mem_dest = 3'(k);
         bus.mem_data = 16'hB000 + 16'(k);
         bus.alu_data = 16'hA000 + 16'(k);
         check("full_mem_ready", 32'(bus.mem_ready), 32'd1);
         expect_write(3'd7, 16'hA000 + 16'(k));
         tick();
      end
      check("full_mem_ready0", 32'(bus.mem_ready), 32'd0);
      check("full_alu_ready0", 32'(bus.alu_ready), 32'd0);
      bus.mem_dest = 3'd4;
      bus.mem_data = 16'hB004;
      bus.alu_data = 16'hA004;
      expect_write(3'd0, 16'hB000);
      tick();
      check("full_mem_ready1", 32'(bus.mem_ready), 32'd1);
      check("full_alu_ready1", 32'(bus.alu_ready), 32'd1);
      expect_write(3'd7, 16'hA004);
      tick();
      bus.mem_valid = 1'b0;
      bus.alu_valid = 1'b0;
      check("full_fifth_in", 32'(bus.mem_ready), 32'd0);
      for (int k = 1; k < 5; k++) begin
         expect_write(3'(k), 16'hB000 + 16'(k));
      end
      repeat (4) tick();
      check("full_drained", 32'(bus.mem_ready), 32'd1);
      tick();
      check("full_idle", 32'(bus.reg_write_en), 32'd0);

      // Scoreboard race: issue to r5 wins over the load write to r5
      bus.issue_valid = 1'b1;
      bus.issue_dest  = 3'd5;
      tick();
      check("race_busy_set", 32'(bus.busy), 32'h20);
      bus.issue_valid = 1'b0;
      bus.mem_valid   = 1'b1;
      bus.mem_dest    = 3'd5;
      bus.mem_data    = 16'h5A5A;
      tick();
      bus.mem_valid   = 1'b0;
      bus.issue_valid = 1'b1;
      expect_write(3'd5, 16'h5A5A);
      tick();
      check("race_load_en", 32'(bus.reg_write_en), 32'd1);
      check("race_busy_kept", 32'(bus.busy), 32'h20);
      bus.issue_valid = 1'b0;
      bus.alu_valid   = 1'b1;
      bus.alu_dest    = 3'd5;
      bus.alu_data    = 16'h0505;
      expect_write(3'd5, 16'h0505);
      tick();
      check("race_busy_clr", 32'(bus.busy), 32'h00);
      bus.alu_valid = 1'b0;
      tick();

      // Reset mid-operation: three loads queued, r1..r3 pending
      bus.alu_valid = 1'b1;
      bus.alu_dest  = 3'd0;
      bus.mem_valid = 1'b1;
      bus.issue_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         bus.mem_dest   = 3'(k + 1);
         bus.mem_data   = 16'hD000 + 16'(k);
         bus.issue_dest = 3'(k + 1);
         bus.alu_data   = 16'hC000 + 16'(k);
         expect_write(3'd0, 16'hC000 + 16'(k));
         tick();
      end
      check("mid_busy", 32'(bus.busy), 32'h0E);
      bus.alu_valid   = 1'b0;
      bus.mem_valid   = 1'b0;
      bus.issue_valid = 1'b0;
      rst = 1'b1;
      #1;
      check("mid_rst_en",        32'(bus.reg_write_en), 32'd0);
      check("mid_rst_busy",      32'(bus.busy),         32'h00);
      check("mid_rst_mem_ready", 32'(bus.mem_ready),    32'd1);
      tick();
      check("mid_rst_alu_ready", 32'(bus.alu_ready), 32'd1);
      rst = 1'b0;
      repeat (4) tick();
      check("post_rst_en",   32'(bus.reg_write_en), 32'd0);
      check("post_rst_busy", 32'(bus.busy),         32'h00);

      check("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/reg_writeback.md
Name: reg_writeback

Overview:
- Write-side master for the 8x16 processor register file. Owns the file's single write port.
- Merges two result producers: the single-cycle ALU path and the multi-cycle load/memory path. Load results are buffered in a small FIFO.
- Emits at most one registered write per cycle to reg_write_en / reg_write_dest / reg_write_data.
- Keeps a pending-write scoreboard (busy mask) that decode uses for hazard stalls.

Parameters:
- DEPTH, 4, load-result FIFO entries (power of 2, >=2)
- STARVE_MAX, 3, cycles a non-empty FIFO head may lose to the ALU before it is forced through (>=1)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- alu_valid  in  1  ALU result offered
- alu_ready  out  1  ALU result accepted this cycle (combinational)
- alu_dest  in  3  ALU destination register
- alu_data  in  16  ALU result
- mem_valid  in  1  load result offered
- mem_ready  out  1  FIFO not full (combinational)
- mem_dest  in  3  load destination register
- mem_data  in  16  load data
- issue_valid  in  1  decode issued an instruction that will write issue_dest
- issue_dest  in  3  destination of the issued instruction
- busy  out  8  scoreboard; bit r = write to r pending
- reg_write_en  out  1  register-file write enable (registered)
- reg_write_dest  out  3  register-file write address (registered)
- reg_write_data  out  16  register-file write data (registered)

Behaviour:
- Reset (async, while rst=1):
  - reg_write_en=0, reg_write_dest=0, reg_write_data=0.
  - FIFO empty (count=0), starve counter=0, busy=8'h00.
  - During and after reset: mem_ready=1, alu_ready=1.
  - Reset mid-operation discards all queued results and pending scoreboard bits.
- Handshakes: a transfer occurs when valid&ready are high at a rising edge. Producers hold dest/data stable while valid=1 and ready=0.
- mem_ready = (count != DEPTH). There is no pass-through when full, even if a dequeue happens the same cycle.
- Arbitration, evaluated each cycle:
  - force = fifo_nonempty && (starve == STARVE_MAX).
  - alu_ready = !force.
  - Source selection:
    - force: FIFO head wins.
    - else alu_valid: ALU wins.
    - else fifo_nonempty: FIFO head wins.
    - else no write.
- Starve counter:
  - Increments when the FIFO is non-empty and the ALU wins.
  - Clears when the FIFO head is written or the FIFO is empty.
  - Saturates at STARVE_MAX.
- Output register: at each edge, reg_write_en <= (a source won). reg_write_dest and reg_write_data load the winner's values. If no source won they hold their previous values with en=0.
- Latency:
  - ALU: accepted at edge N, write visible on outputs after edge N, committed to the file at edge N+1.
  - Load: enqueued at edge N, earliest output after edge N+1 (no bypass).
- FIFO:
  - In-order. Pointers are log2(DEPTH) bits with natural wrap; count is log2(DEPTH)+1 bits.
  - Simultaneous push and pop when not full: count unchanged.
- Scoreboard, per bit at each edge:
  - set if issue_valid && issue_dest==r;
  - else clear if a write to r is selected this cycle;
  - set wins over clear on the same register in the same cycle.
  - busy is registered and reflects state after the edge.
- Same destination from both producers in one cycle: ALU is written first, load next. The architectural result is the later (load) value. This is the intended program order for this pipeline.
- No error detection for writes to non-busy registers; they are legal.

Decomposition:
- Package wb_pkg:
  - REG_ADDR_W=3, DATA_W=16, NUM_REGS=8.
  - typedef wb_req_t {dest[2:0], data[15:0]}.
  - enum wb_src_t {SRC_NONE, SRC_ALU, SRC_MEM}.
- Sub-module wb_fifo (DEPTH-entry synchronous FIFO of wb_req_t with push/pop/full/empty/count). Top level holds the arbiter, starve counter, scoreboard and output register.

Test Plan:
- Reset mid-op: 3 loads queued, busy=8'h0E, assert rst -> after 1 cycle reg_write_en=0, busy=0, mem_ready=1. Post-reset there are no writes.
- ALU only: issue dest=3, then alu_valid dest=3 data=16'h1234 at edge N -> after N reg_write_en=1, dest=3, data=16'h1234; busy[3]=0.
- Conflict: alu_valid (r1=16'hAAAA) and FIFO head (r2=16'h5555) same cycle -> ALU write on edge N, load write on edge N+1. alu_ready stays 1.
- Starvation (STARVE_MAX=3): alu_valid held high with 1 queued load -> 3 ALU writes, then alu_ready=0 for one cycle while the load is written, then ALU resumes.
- FIFO full (DEPTH=4): continuous alu_valid plus 4 loads -> mem_ready=0 after the 4th push. It returns to 1 the cycle after the first forced pop, and the fifth load is accepted.
- Scoreboard race: busy[5]=1, a load to r5 is written while issue_valid dest=5 is high the same cycle -> busy[5] stays 1; the next write to r5 clears it.
